dac_dwa_scheduler: RTL and testbench

Sequencer that owns the bank of unit current cells in front of the per-cell non-overlapping ON/ON_N switch drivers. It accepts DAC codes over a valid/ready handshake. It converts each code into a registered thermometer word of cell enables, using either a static order or data-weighted-averaging rotation to spread mismatch. It enforces a settle window after every update so the switch-driver chains finish their break-before-make transition before the next code is applied.

---
 rtl/dac_dwa_scheduler.sv | 143 ++++++++++++++
 tb/tb_dac_dwa_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_dwa_scheduler.sv
// DAC cell sequencer: accepts codes over valid/ready and drives a registered thermometer
// word of unit-cell enables, in either static or DWA-rotated order, with a post-update settle window.
module dac_dwa_scheduler #(
    parameter int IN_WIDTH      = 256,
    parameter int CODE_W        = $clog2(IN_WIDTH + 1),
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        mode,
    input  logic                        code_valid,
    output logic                        code_ready,
    input  logic [CODE_W-1:0]           code,
    input  logic                        sat_clr,
    output logic [IN_WIDTH-1:0]         thermo,
    output logic [$clog2(IN_WIDTH)-1:0] ptr,
    output logic                        busy,
    output logic                        sat
);

    localparam int PTR_W = $clog2(IN_WIDTH);
    // One bit of headroom so ptr + n and i + IN_WIDTH - base never overflow.
    localparam int SUM_W = ((CODE_W > PTR_W) ? CODE_W : PTR_W) + 1;
    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    localparam logic [SUM_W-1:0] CELLS    = SUM_W'(IN_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_READY,
        ST_SETTLE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;

    logic                 clamp;
    logic [SUM_W-1:0]     n;
    logic [SUM_W-1:0]     base;
    logic [SUM_W-1:0]     sum;
    logic [SUM_W-1:0]     idx;
    logic [SUM_W-1:0]     off;
    logic [PTR_W-1:0]     ptr_next;
    logic [IN_WIDTH-1:0]  thermo_next;

    // Cell i is on when its distance from the rotation base, modulo IN_WIDTH, is below n.
    // Static mode is the same rule with the base pinned to cell 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        clamp       = 1'b0;
        n           = '0;
        base        = '0;
        sum         = '0;
        idx         = '0;
        off         = '0;
        ptr_next    = ptr;
        thermo_next = '0;

        clamp = SUM_W'(code) > CELLS;
        n     = clamp ? CELLS : SUM_W'(code);
        base  = mode ? SUM_W'(ptr) : '0;

        sum = SUM_W'(ptr) + n;
        if (sum >= CELLS) begin
            sum = sum - CELLS;
        end
        ptr_next = PTR_W'(sum);

        for (int i = 0; i < IN_WIDTH; i++) begin
            idx            = SUM_W'(i);
            off            = (idx >= base) ? (idx - base) : (idx + CELLS - base);
            thermo_next[i] = off < n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_OFF;
            cnt        <= '0;
            thermo     <= '0;
            ptr        <= '0;
            code_ready <= 1'b0;
            busy       <= 1'b0;
            sat        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so the later clamp set overrides this clear.
            if (sat_clr) begin
                sat <= 1'b0;
            end

            if (!en) begin
                state      <= ST_OFF;
                cnt        <= '0;
                thermo     <= '0;
                code_ready <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    ST_OFF: begin
                        state      <= ST_READY;
                        code_ready <= 1'b1;
                    end

                    ST_READY: begin
                        if (code_valid && code_ready) begin
                            thermo <= thermo_next;
                            if (mode) begin
                                ptr <= ptr_next;
                            end
                            if (clamp) begin
                                sat <= 1'b1;
                            end
                            if (SETTLE_CYCLES > 0) begin
                                state      <= ST_SETTLE;
                                cnt        <= CNT_LOAD;
                                code_ready <= 1'b0;
                                busy       <= 1'b1;
                            end
                        end
                    end

                    ST_SETTLE: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state      <= ST_READY;
                            code_ready <= 1'b1;
                            busy       <= 1'b0;
                        end
                    end

                    default: begin
                        state      <= ST_OFF;
                        code_ready <= 1'b0;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dac_dwa_scheduler.sv
// Bench for dac_dwa_scheduler: an 8-cell instance with a 3-cycle settle window and an
// 8-cell instance with no settle window, sharing clock and reset.
module tb_dac_dwa_scheduler;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int S  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          en = 1'b0, mode = 1'b0, code_valid = 1'b0, sat_clr = 1'b0;
    logic [CW-1:0] code = '0;
    logic          code_ready, busy, sat;
    logic [W-1:0]  thermo;
    logic [2:0]    ptr;

    logic          en_z = 1'b0, mode_z = 1'b0, cv_z = 1'b0, clr_z = 1'b0;
    logic [CW-1:0] code_z = '0;
    logic          ready_z, busy_z, sat_z;
    logic [W-1:0]  thermo_z;
    logic [2:0]    ptr_z;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dac_dwa_scheduler #(.IN_WIDTH(W), .CODE_W(CW), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .code_valid(code_valid),
        .code_ready(code_ready), .code(code), .sat_clr(sat_clr), .thermo(thermo),
        .ptr(ptr), .busy(busy), .sat(sat)
    );

    dac_dwa_scheduler #(.IN_WIDTH(W), .CODE_W(CW), .SETTLE_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .en(en_z), .mode(mode_z), .code_valid(cv_z),
        .code_ready(ready_z), .code(code_z), .sat_clr(clr_z), .thermo(thermo_z),
        .ptr(ptr_z), .busy(busy_z), .sat(sat_z)
    );

    typedef struct {
        logic         mode;
        logic [CW-1:0] code;
        logic         clr;
        logic [W-1:0] exp_thermo;
        logic [2:0]   exp_ptr;
        logic         exp_sat;
    } vec_t;

    typedef struct {
        logic [W-1:0] thermo;
        logic [2:0]   ptr;
        logic         sat;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one code at a negedge once code_ready is up, then compare the result one edge later.
    task automatic accept_code(input logic m, input logic [CW-1:0] c, input logic clr,
                               input logic [W-1:0] et, input logic [2:0] ep, input logic es);
        exp_t e;
        exp_t got;
        int   w = 0;
        while (!code_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_accept", code_ready, 1);
        mode       = m;
        code       = c;
        sat_clr    = clr;
        code_valid = 1'b1;
        e.thermo = et; e.ptr = ep; e.sat = es;
        sb.push_back(e);
        @(negedge clk);
        code_valid = 1'b0;
        sat_clr    = 1'b0;
        got = sb.pop_front();
        check("thermo", thermo, got.thermo);
        check("ptr", ptr, got.ptr);
        check("sat", sat, got.sat);
    endtask

    // Count the negedges (starting just after the accept) where code_ready stays low.
    task automatic settle_check();
        int low    = 0;
        int busy_n = 0;
        while (!code_ready && low < 20) begin
            if (busy) busy_n++;
            low++;
            @(negedge clk);
        end
        check("ready_low_cycles", low, S);
        check("busy_cycles", busy_n, S);
        check("busy_after_settle", busy, 0);
    endtask

    initial begin
        //            mode  code   clr   thermo        ptr   sat
        vecs[0] = '{1'b0, 4'd5,  1'b0, 8'b0001_1111, 3'd0, 1'b0};
        vecs[1] = '{1'b1, 4'd6,  1'b0, 8'b0011_1111, 3'd6, 1'b0};
        vecs[2] = '{1'b1, 4'd4,  1'b0, 8'b1100_0011, 3'd2, 1'b0};
        vecs[3] = '{1'b1, 4'd8,  1'b0, 8'b1111_1111, 3'd2, 1'b0};
        vecs[4] = '{1'b1, 4'd0,  1'b0, 8'b0000_0000, 3'd2, 1'b0};
        vecs[5] = '{1'b1, 4'd3,  1'b0, 8'b0001_1100, 3'd5, 1'b0};
        vecs[6] = '{1'b0, 4'd2,  1'b0, 8'b0000_0011, 3'd5, 1'b0};
        vecs[7] = '{1'b1, 4'd12, 1'b0, 8'b1111_1111, 3'd5, 1'b1};
        vecs[8] = '{1'b1, 4'd5,  1'b0, 8'b1110_0011, 3'd2, 1'b1};
        vecs[9] = '{1'b0, 4'd9,  1'b1, 8'b1111_1111, 3'd2, 1'b1};

        // Reset and enable sequencing
        @(negedge clk);
        check("rst_thermo", thermo, 0);
        check("rst_ptr", ptr, 0);
        check("rst_ready", code_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_sat", sat, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("off_ready", code_ready, 0);
        check("off_thermo", thermo, 0);
        en   = 1'b1;
        en_z = 1'b1;
        @(negedge clk);
        check("en_ready", code_ready, 1);
        check("en_ready_z", ready_z, 1);

        // Table of codes through the settle-window instance
        for (int i = 0; i < 10; i++) begin
            accept_code(vecs[i].mode, vecs[i].code, vecs[i].clr,
                        vecs[i].exp_thermo, vecs[i].exp_ptr, vecs[i].exp_sat);
            settle_check();
        end

        // Lone sat_clr clears the flag
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        check("sat_clr_lone", sat, 0);

        // Enable drop mid-settle keeps ptr; the next DWA code starts from it
        accept_code(1'b1, 4'd3, 1'b0, 8'b0001_1100, 3'd5, 1'b0);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("drop_thermo", thermo, 0);
        check("drop_ready", code_ready, 0);
        check("drop_busy", busy, 0);
        check("drop_ptr", ptr, 5);
        en = 1'b1;
        @(negedge clk);
        check("reen_ready", code_ready, 1);
        accept_code(1'b1, 4'd2, 1'b0, 8'b0110_0000, 3'd7, 1'b0);
        settle_check();

        // en low on an accept edge drops the code
        en         = 1'b0;
        code_valid = 1'b1;
        mode       = 1'b1;
        code       = 4'd12;
        @(negedge clk);
        code_valid = 1'b0;
        check("enwin_thermo", thermo, 0);
        check("enwin_ptr", ptr, 7);
        check("enwin_sat", sat, 0);
        check("enwin_ready", code_ready, 0);
        en = 1'b1;
        @(negedge clk);
        check("enwin_reen", code_ready, 1);

        // Zero settle window: back-to-back accepts with valid held high
        mode_z = 1'b1;
        code_z = 4'd1;
        cv_z   = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            logic [W-1:0] oh;
            @(negedge clk);
            oh = 8'h01 << (k - 1);
            check("z_ptr", ptr_z, k);
            check("z_thermo", thermo_z, oh);
            check("z_ready", ready_z, 1);
        end
        cv_z = 1'b0;

        // Asynchronous reset clears outputs without waiting for an edge
        accept_code(1'b1, 4'd2, 1'b0, 8'b1000_0001, 3'd1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_thermo", thermo, 0);
        check("arst_ptr", ptr, 0);
        check("arst_ready", code_ready, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_resume_ready", code_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
